// File: rtl/score_bank_arbiter.sv
// score_bank_arbiter: round-robin sharing of PARALLEL score BRAM banks among PARALLEL engines.
// Optional ARB_STALL_CNT_EN adds saturating per-requester stall counters.
module score_bank_arbiter #(
  parameter int PARALLEL   = 4,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int BANK_SIZE  = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [PARALLEL-1:0]            req,
  input  logic [PARALLEL-1:0]            req_we,
  input  logic [ADDR_WIDTH*PARALLEL-1:0] req_addr,
  input  logic [DATA_WIDTH*PARALLEL-1:0] req_wdata,
  output logic [PARALLEL-1:0]            gnt,
  output logic [PARALLEL-1:0]            stall,
  output logic [PARALLEL-1:0]            rvalid,
  output logic [DATA_WIDTH*PARALLEL-1:0] rdata,
  output logic [ADDR_WIDTH*PARALLEL-1:0] bank_addr,
  output logic [PARALLEL-1:0]            bank_we,
  output logic [DATA_WIDTH*PARALLEL-1:0] bank_wdata,
  input  logic [DATA_WIDTH*PARALLEL-1:0] bank_rdata,
  output logic                           oob_err,
  output logic [CNT_WIDTH*PARALLEL-1:0]  stall_cnt
);
  localparam int BW = PARALLEL > 1 ? $clog2(PARALLEL) : 1;
  logic [PARALLEL-1:0][BW-1:0] ptr, dec_bank, win, p1_b, p2_b;
  logic [ADDR_WIDTH-1:0] dec_loc [PARALLEL];
  logic [PARALLEL-1:0] in_rng, oob, gr, bgnt, p1_v, p1_o, p2_v, p2_o;
  // First bank whose upper bound exceeds the address owns it; nothing matches past the last bank.
  always_comb begin
    dec_bank = '0;
    in_rng = '0;
    for (int i = 0; i < PARALLEL; i++) begin
      dec_loc[i] = '0;
      for (int b = 0; b < PARALLEL; b++)
        if (!in_rng[i] && req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] < ADDR_WIDTH'((b+1)*BANK_SIZE)) begin
          in_rng[i] = 1'b1;
          dec_bank[i] = BW'(b);
          dec_loc[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] - ADDR_WIDTH'(b*BANK_SIZE);
        end
    end
  end
  assign oob = req & ~in_rng;
  always_comb begin : arb
    int j;
    j = 0;
    gr = '0;
    bgnt = '0;
    win = '0;
    for (int b = 0; b < PARALLEL; b++)
      for (int k = 0; k < PARALLEL; k++) begin
        j = (int'(ptr[b]) + k) % PARALLEL;
        if (!bgnt[b] && req[j] && in_rng[j] && dec_bank[j] == BW'(b)) begin
          bgnt[b] = 1'b1;
          win[b] = BW'(j);
          gr[j] = 1'b1;
        end
      end
  end
  assign gnt = rst_n ? (gr | oob) : '0;
  assign stall = rst_n ? (req & ~gnt) : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      bank_we <= '0;
      bank_addr <= '0;
      bank_wdata <= '0;
      oob_err <= 1'b0;
      p1_v <= '0;
      p1_o <= '0;
      p1_b <= '0;
      p2_v <= '0;
      p2_o <= '0;
      p2_b <= '0;
    end else begin
      for (int b = 0; b < PARALLEL; b++) begin
        bank_we[b] <= bgnt[b] & req_we[win[b]];
        if (bgnt[b]) begin
          ptr[b] <= (win[b] == BW'(PARALLEL-1)) ? '0 : win[b] + 1'b1;
          bank_addr[b*ADDR_WIDTH +: ADDR_WIDTH] <= dec_loc[win[b]];
          bank_wdata[b*DATA_WIDTH +: DATA_WIDTH] <= req_wdata[int'(win[b])*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      oob_err <= oob_err | (|oob);
      p1_v <= gnt & ~req_we;
      p1_o <= oob;
      p1_b <= dec_bank;
      p2_v <= p1_v;
      p2_o <= p1_o;
      p2_b <= p1_b;
    end
  end
  // BRAM data arrives the cycle after bank_addr, so the response mux is combinational.
  assign rvalid = p2_v;
  always_comb begin
    rdata = '0;
    for (int i = 0; i < PARALLEL; i++)
      rdata[i*DATA_WIDTH +: DATA_WIDTH] = (p2_v[i] && !p2_o[i]) ? bank_rdata[int'(p2_b[i])*DATA_WIDTH +: DATA_WIDTH] : '0;
  end
`ifdef ARB_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= '0;
    else
      for (int i = 0; i < PARALLEL; i++)
        if (stall[i] && stall_cnt[i*CNT_WIDTH +: CNT_WIDTH] != '1)
          stall_cnt[i*CNT_WIDTH +: CNT_WIDTH] <= stall_cnt[i*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
  end
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_score_bank_arbiter.sv
// tb_score_bank_arbiter: random traffic against a behavioural bank/round-robin model.
module tb_score_bank_arbiter;
  localparam int P = 4, AW = 13, DW = 32, BS = 10, CW = 16, N = P*BS;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic [P-1:0] req = '0, req_we = '0, gnt, stall, rvalid, bank_we;
  logic [AW*P-1:0] req_addr = '0, bank_addr;
  logic [DW*P-1:0] req_wdata = '0, rdata, bank_wdata, bank_rdata = '0;
  logic [CW*P-1:0] stall_cnt;
  logic oob_err;
  score_bank_arbiter #(.PARALLEL(P), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_SIZE(BS), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .stall(stall), .rvalid(rvalid), .rdata(rdata), .bank_addr(bank_addr), .bank_we(bank_we),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata), .oob_err(oob_err), .stall_cnt(stall_cnt)
  );
  logic [DW-1:0] bram [N];
  logic [DW-1:0] gmem [N];
  always @(posedge clk) begin
    for (int b = 0; b < P; b++) begin
      int a;
      a = b*BS + int'(bank_addr[b*AW +: AW]);
      if (a < N) begin
        bank_rdata[b*DW +: DW] <= bram[a];
        if (bank_we[b]) bram[a] <= bank_wdata[b*DW +: DW];
      end
    end
  end
  int n_chk = 0, n_fail = 0;
  int ptr_m [P];
  int cnt_m [P];
  logic [P-1:0] e1v, e2v, ewe;
  logic [DW-1:0] e1d [P];
  logic [DW-1:0] e2d [P];
  logic [AW-1:0] ea [P];
  logic [DW-1:0] ewd [P];
  logic eoob;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < P; i++) begin
      ptr_m[i] = 0;
      cnt_m[i] = 0;
      e1d[i] = '0;
      e2d[i] = '0;
      ea[i] = '0;
      ewd[i] = '0;
    end
    e1v = '0;
    e2v = '0;
    ewe = '0;
    eoob = 1'b0;
  endtask
  task automatic check_reset(input string tag);
    check({tag, ".gnt"}, 64'(gnt), 0);
    check({tag, ".stall"}, 64'(stall), 0);
    check({tag, ".rvalid"}, 64'(rvalid), 0);
    check({tag, ".rdata"}, 64'(rdata[63:0]), 0);
    check({tag, ".bank_we"}, 64'(bank_we), 0);
    check({tag, ".bank_addr"}, 64'(bank_addr[51:0]), 0);
    check({tag, ".bank_wdata"}, 64'(bank_wdata[63:0]), 0);
    check({tag, ".oob_err"}, 64'(oob_err), 0);
    check({tag, ".stall_cnt"}, stall_cnt, 0);
  endtask
  // One cycle of the reference: check outputs seen this cycle, then advance to the next edge.
  task automatic step();
    logic [P-1:0] g;
    logic [CW*P-1:0] ec;
    int a [P];
    int bk [P];
    bit in_r [P];
    g = '0;
    ec = '0;
    for (int i = 0; i < P; i++) begin
      a[i] = int'(req_addr[i*AW +: AW]);
      in_r[i] = a[i] < N;
      bk[i] = a[i] / BS;
      if (req[i] && !in_r[i]) g[i] = 1'b1;
    end
    for (int b = 0; b < P; b++)
      for (int k = 0; k < P; k++) begin
        int j;
        j = (ptr_m[b] + k) % P;
        if (req[j] && in_r[j] && bk[j] == b) begin
          g[j] = 1'b1;
          ptr_m[b] = (j + 1) % P;
          break;
        end
      end
`ifdef ARB_STALL_CNT_EN
    for (int i = 0; i < P; i++) ec[i*CW +: CW] = CW'(cnt_m[i]);
`endif
    check("gnt", 64'(gnt), 64'(g));
    check("stall", 64'(stall), 64'(req & ~g));
    check("rvalid", 64'(rvalid), 64'(e2v));
    for (int i = 0; i < P; i++)
      if (e2v[i]) check($sformatf("rdata%0d", i), 64'(rdata[i*DW +: DW]), 64'(e2d[i]));
    check("bank_we", 64'(bank_we), 64'(ewe));
    for (int b = 0; b < P; b++) begin
      check($sformatf("bank_addr%0d", b), 64'(bank_addr[b*AW +: AW]), 64'(ea[b]));
      check($sformatf("bank_wdata%0d", b), 64'(bank_wdata[b*DW +: DW]), 64'(ewd[b]));
    end
    check("oob_err", 64'(oob_err), 64'(eoob));
    check("stall_cnt", stall_cnt, ec);
    ewe = '0;
    for (int i = 0; i < P; i++)
      if (g[i] && in_r[i]) begin
        ewe[bk[i]] = req_we[i];
        ea[bk[i]] = AW'(a[i] % BS);
        ewd[bk[i]] = req_wdata[i*DW +: DW];
        if (req_we[i]) gmem[a[i]] = req_wdata[i*DW +: DW];
      end
    e2v = e1v;
    for (int i = 0; i < P; i++) begin
      e2d[i] = e1d[i];
      e1v[i] = g[i] && !req_we[i];
      e1d[i] = in_r[i] ? gmem[a[i]] : '0;
      if (req[i] && !in_r[i]) eoob = 1'b1;
      if (req[i] && !g[i] && cnt_m[i] < (1 << CW) - 1) cnt_m[i]++;
    end
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin
      bram[i] = $urandom;
      gmem[i] = bram[i];
    end
    model_reset();
    req = '1;
    repeat (3) @(negedge clk);
    check_reset("reset");
    @(posedge clk);
    #1 rst_n = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < P; i++) begin
        req_wdata[i*DW +: DW] = $urandom;
        if (c >= 100 && c < 106) begin
          req[i] = 1'b1;
          req_we[i] = 1'b1;
          req_addr[i*AW +: AW] = AW'(i*BS + 2);
        end else if (c >= 200 && c < 208) begin
          req[i] = 1'b1;
          req_we[i] = 1'b0;
          req_addr[i*AW +: AW] = AW'(BS + i);
        end else if (c == 1500) begin
          req[i] = (i == 0);
          req_we[i] = 1'b0;
          req_addr[i*AW +: AW] = 3;
        end else begin
          req[i] = $urandom_range(0, 3) != 0;
          req_we[i] = $urandom_range(0, 2) == 0;
          if ($urandom_range(0, 63) == 0) req_addr[i*AW +: AW] = AW'(N + $urandom_range(0, 9));
          else if (c % 400 < 100) req_addr[i*AW +: AW] = AW'(BS + $urandom_range(0, 3));
          else req_addr[i*AW +: AW] = AW'($urandom_range(0, P-1)*BS + $urandom_range(0, BS-1));
        end
      end
      @(negedge clk);
      step();
      @(posedge clk);
      #1;
      if (c == 1500) begin
        rst_n = 0;
        req = '1;
        #1 check_reset("midreset");
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
